// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write and allocate bus of the scoreboarded register file
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Ra, Rb, Rw, Rd;
  logic [DATA_W-1:0] busA, busB, busW;
  logic              rdyA, rdyB, RegWr, RegAlloc;
  logic [ADDR_W:0]   BusyCnt;
  modport master (
    output Ra, Rb, Rw, Rd, busW, RegWr, RegAlloc,
    input  busA, busB, rdyA, rdyB, BusyCnt
  );
  modport slave (
    input  Ra, Rb, Rw, Rd, busW, RegWr, RegAlloc,
    output busA, busB, rdyA, rdyB, BusyCnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: two-read one-write register file with per-register busy scoreboard
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         WrClk,
  input logic         Rst_n,
  regfile_sb_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW = ADDR_W + 1;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, busyNext;
  logic [ADDR_W:0]   busyCnt, cntNext;
  logic              wrEn, allocEn, zeroA, zeroB, bypA, bypB;
  // Register 0 swallows writes and allocates when hardwired, so it never goes busy
  assign wrEn    = Rst_n && rf.RegWr && !(ZERO_REG != 0 && rf.Rw == '0);
  assign allocEn = Rst_n && rf.RegAlloc && !(ZERO_REG != 0 && rf.Rd == '0);
  assign zeroA   = ZERO_REG != 0 && rf.Ra == '0;
  assign zeroB   = ZERO_REG != 0 && rf.Rb == '0;
  assign bypA    = BYPASS != 0 && wrEn && rf.Ra == rf.Rw;
  assign bypB    = BYPASS != 0 && wrEn && rf.Rb == rf.Rw;
  assign rf.busA = zeroA ? '0 : bypA ? rf.busW : regs[rf.Ra];
  assign rf.busB = zeroB ? '0 : bypB ? rf.busW : regs[rf.Rb];
  assign rf.rdyA = zeroA || bypA || !busy[rf.Ra];
  assign rf.rdyB = zeroB || bypB || !busy[rf.Rb];
  assign rf.BusyCnt = busyCnt;
  // Allocate is applied after the write clear so it wins on the same address
  always_comb begin
    busyNext = busy;
    if (wrEn) busyNext[rf.Rw] = 1'b0;
    if (allocEn) busyNext[rf.Rd] = 1'b1;
    cntNext = '0;
    for (int i = 0; i < DEPTH; i++) cntNext = cntNext + CW'(busyNext[i]);
  end
  always_ff @(posedge WrClk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      if (wrEn) regs[rf.Rw] <= rf.busW;
      busy    <= busyNext;
      busyCnt <= cntNext;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of three regfile_sb configurations against an array model
module tb_regfile_sb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ra = '0, rb = '0, rw = '0, rd = '0;
  logic [31:0] busW = '0;
  logic regWr = 1'b0, regAlloc = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  regfile_sb_if #(32, 5) ifA ();
  regfile_sb_if #(32, 5) ifB ();
  regfile_sb_if #(32, 5) ifC ();
  assign ifA.Ra = ra; assign ifA.Rb = rb; assign ifA.Rw = rw; assign ifA.Rd = rd;
  assign ifA.busW = busW; assign ifA.RegWr = regWr; assign ifA.RegAlloc = regAlloc;
  assign ifB.Ra = ra; assign ifB.Rb = rb; assign ifB.Rw = rw; assign ifB.Rd = rd;
  assign ifB.busW = busW; assign ifB.RegWr = regWr; assign ifB.RegAlloc = regAlloc;
  assign ifC.Ra = ra; assign ifC.Rb = rb; assign ifC.Rw = rw; assign ifC.Rd = rd;
  assign ifC.busW = busW; assign ifC.RegWr = regWr; assign ifC.RegAlloc = regAlloc;

  regfile_sb dA (.WrClk(clk), .Rst_n(rst_n), .rf(ifA));
  regfile_sb #(.BYPASS(0)) dB (.WrClk(clk), .Rst_n(rst_n), .rf(ifB));
  regfile_sb #(.ZERO_REG(0)) dC (.WrClk(clk), .Rst_n(rst_n), .rf(ifC));

  // Model state: index 0 = register 0 hardwired (dA, dB), index 1 = ordinary register 0 (dC)
  logic [31:0] mMem [2][32];
  logic        mBusy [2][32];
  int          mCnt [2];

  function automatic bit wrOk(int s);
    return rst_n && regWr && !(s == 0 && rw == 0);
  endfunction
  function automatic bit allocOk(int s);
    return rst_n && regAlloc && !(s == 0 && rd == 0);
  endfunction
  function automatic logic [32:0] expRead(int s, bit bp, logic [4:0] a);
    if (s == 0 && a == 0) return {1'b1, 32'h0};
    if (bp && wrOk(s) && a == rw) return {1'b1, busW};
    return {~mBusy[s][a], mMem[s][a]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) begin mMem[s][i] = '0; mBusy[s][i] = 1'b0; end
      end else begin
        if (wrOk(s)) begin mMem[s][rw] = busW; mBusy[s][rw] = 1'b0; end
        if (allocOk(s)) mBusy[s][rd] = 1'b1;
      end
      mCnt[s] = 0;
      for (int i = 0; i < 32; i++) mCnt[s] += int'(mBusy[s][i]);
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", n, $time, act, exp);
    end
  endtask

  task automatic chkDut(input string n, input int s, input bit bp, input logic [31:0] a, input logic [31:0] b,
                        input logic ya, input logic yb, input logic [5:0] cnt);
    logic [32:0] ea, eb;
    ea = expRead(s, bp, ra);
    eb = expRead(s, bp, rb);
    chk({n, ".busA"}, 64'(a), 64'(ea[31:0]));
    chk({n, ".busB"}, 64'(b), 64'(eb[31:0]));
    chk({n, ".rdyA"}, 64'(ya), 64'(ea[32]));
    chk({n, ".rdyB"}, 64'(yb), 64'(eb[32]));
    chk({n, ".BusyCnt"}, 64'(cnt), 64'(mCnt[s]));
  endtask

  always @(negedge clk) begin
    chkDut("dA", 0, 1'b1, ifA.busA, ifA.busB, ifA.rdyA, ifA.rdyB, ifA.BusyCnt);
    chkDut("dB", 0, 1'b0, ifB.busA, ifB.busB, ifB.rdyA, ifB.rdyB, ifB.BusyCnt);
    chkDut("dC", 1, 1'b1, ifC.busA, ifC.busB, ifC.rdyA, ifC.rdyB, ifC.BusyCnt);
  end

  task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w, input logic [4:0] d,
                      input logic [31:0] dw, input logic we, input logic al);
    @(posedge clk);
    #1;
    ra = a; rb = b; rw = w; rd = d; busW = dw; regWr = we; regAlloc = al;
    #1;
  endtask

  function automatic logic [4:0] rndAddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    ra = 5'd3; rw = 5'd3; busW = 32'hDEADBEEF; regWr = 1'b1;
    #1;
    chk("rst.busA", 64'(ifA.busA), 64'h0);
    chk("rst.rdyA", 64'(ifA.rdyA), 64'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1; regWr = 1'b0; ra = '0; rw = '0; busW = '0;
    step(0, 0, 1, 0, 32'hA5A5A5A5, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("w1.busA", 64'(ifA.busA), 64'hA5A5A5A5);
    chk("w1.busB", 64'(ifA.busB), 64'h0);
    chk("w1.rdyA", 64'(ifA.rdyA), 64'h1);
    chk("w1.rdyB", 64'(ifA.rdyB), 64'h1);
    step(0, 0, 0, 0, 32'hFFFFFFFF, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("r0.busA", 64'(ifA.busA), 64'h0);
    chk("r0.rdyA", 64'(ifA.rdyA), 64'h1);
    chk("r0.BusyCnt", 64'(ifA.BusyCnt), 64'h0);
    chk("r0nz.busA", 64'(ifC.busA), 64'hFFFFFFFF);
    chk("r0nz.rdyA", 64'(ifC.rdyA), 64'h0);
    step(0, 0, 0, 2, 0, 0, 1);
    step(2, 0, 0, 0, 0, 0, 0);
    chk("al2.rdyA", 64'(ifA.rdyA), 64'h0);
    chk("al2.BusyCnt", 64'(ifA.BusyCnt), 64'h1);
    step(2, 0, 2, 0, 32'h6B6B6B6B, 1, 0);
    chk("byp.busA", 64'(ifA.busA), 64'h6B6B6B6B);
    chk("byp.rdyA", 64'(ifA.rdyA), 64'h1);
    chk("nobyp.busA", 64'(ifB.busA), 64'h0);
    chk("nobyp.rdyA", 64'(ifB.rdyA), 64'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wb2.BusyCnt", 64'(ifA.BusyCnt), 64'h0);
    step(0, 0, 3, 3, 32'h12345678, 1, 1);
    step(3, 0, 0, 0, 0, 0, 0);
    chk("wa3.busA", 64'(ifB.busA), 64'h12345678);
    chk("wa3.rdyA", 64'(ifB.rdyA), 64'h0);
    chk("wa3.BusyCnt", 64'(ifA.BusyCnt), 64'h1);
    step(4, 0, 4, 0, 32'h0000BEEF, 1, 0);
    chk("nobyp4.busA", 64'(ifB.busA), 64'h0);
    step(4, 0, 0, 0, 0, 0, 0);
    chk("nobyp4n.busA", 64'(ifB.busA), 64'h0000BEEF);
    for (int i = 1; i < 32; i++) step(0, 0, 0, 5'(i), 0, 0, 1);
    step(0, 0, 0, 5, 0, 0, 1);
    chk("full.BusyCnt", 64'(ifA.BusyCnt), 64'd31);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("full2.BusyCnt", 64'(ifA.BusyCnt), 64'd31);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.BusyCnt", 64'(ifA.BusyCnt), 64'h0);
    chk("arstC.BusyCnt", 64'(ifC.BusyCnt), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (800) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 49) != 0);
      ra = rndAddr(); rb = rndAddr(); rw = rndAddr(); rd = rndAddr();
      busW = $urandom; regWr = $urandom_range(0, 1) == 1; regAlloc = $urandom_range(0, 2) != 0;
    end
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL provide parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.

Ports:
REQ-005 SHALL have port WrClk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports Ra and Rb, input, ADDR_W each, read addresses for ports A and B.
REQ-008 SHALL have ports busA and busB, output, DATA_W each, read data for ports A and B.
REQ-009 SHALL have ports rdyA and rdyB, output, 1 each; high means the read data is valid, i.e. not awaiting writeback.
REQ-010 SHALL have port Rw, input, ADDR_W, write address.
REQ-011 SHALL have port busW, input, DATA_W, write data.
REQ-012 SHALL have port RegWr, input, 1, write enable; a write also clears the busy bit of Rw.
REQ-013 SHALL have port Rd, input, ADDR_W, allocate address.
REQ-014 SHALL have port RegAlloc, input, 1, allocate enable; sets the busy bit of Rd.
REQ-015 SHALL have port BusyCnt, output, ADDR_W+1, number of registers currently busy.

Function
REQ-016 Reads SHALL be combinational: busA = reg[Ra] and busB = reg[Rb], with zero added read latency.
REQ-017 rdyA SHALL equal ~busy[Ra]; rdyB SHALL equal ~busy[Rb], both combinational.
REQ-018 With BYPASS=1, RegWr=1 and Ra==Rw (write not suppressed), busA SHALL be busW and rdyA SHALL be 1 in the same cycle; port B behaves identically.
REQ-019 With BYPASS=0, read ports SHALL show only stored state; a written value becomes visible the cycle after the edge.
REQ-020 A write with RegWr=1 SHALL store busW into reg[Rw] at the rising edge of WrClk.
REQ-021 A write with RegWr=1 SHALL clear busy[Rw] at the same edge.
REQ-022 With RegAlloc=1, busy[Rd] SHALL be set at the rising edge.
REQ-023 Simultaneous RegWr and RegAlloc to the same address SHALL write the data and leave busy=1 (allocate wins).
REQ-024 Allocating an already-busy register SHALL keep busy=1 and SHALL leave BusyCnt unchanged.
REQ-025 Writing a non-busy register SHALL update the data and SHALL leave BusyCnt unchanged.
REQ-026 BusyCnt SHALL be registered and equal to the population count of busy[] after each edge.
REQ-027 BusyCnt SHALL change per edge by -1, 0, +1, or (alloc of a non-busy register and write of a different busy register) 0.
REQ-028 BusyCnt SHALL never wrap: maximum 2**ADDR_W, minimum 0.
REQ-029 With ZERO_REG=1, writes and allocates to address 0 SHALL be ignored.
REQ-030 With ZERO_REG=1, reads of address 0 SHALL return 0 with rdy=1, and bypass SHALL NOT apply to address 0.
REQ-031 With ZERO_REG=0, register 0 SHALL behave as any other register.
REQ-032 Ra, Rb, Rd and Rw SHALL be fully independent; any combination, including all equal, is legal in one cycle.

Reset
REQ-033 Rst_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0 and BusyCnt to 0, regardless of WrClk.
REQ-034 While Rst_n=0, rdyA=rdyB=1 and busA=busB=0 for any address, and RegWr and RegAlloc are ignored.
REQ-035 Reset deasserted mid-operation SHALL lose pending allocations, and the first edge after release SHALL process inputs normally.

Verification
REQ-036 Reset, then write Rw=1 with busW=A5A5A5A5 and read Ra=1, Rb=0 -> busA=A5A5A5A5, busB=00000000, rdyA=rdyB=1.
REQ-037 Write Rw=0 with FFFFFFFF, then alloc Rd=0, then read Ra=0 -> busA=00000000, rdyA=1, BusyCnt=0 (ZERO_REG=1).
REQ-038 Alloc Rd=2 -> next cycle rdyA=0 at Ra=2 and BusyCnt=1; write Rw=2 with 6B6B6B6B while Ra=2 -> same cycle busA=6B6B6B6B and rdyA=1 (BYPASS=1); next cycle BusyCnt=0.
REQ-039 Same-cycle RegWr and RegAlloc on register 3 with busW=12345678 -> reg[3]=12345678, busy[3]=1, BusyCnt increments by 1.
REQ-040 Alloc registers 1..31 on consecutive cycles, then one extra alloc of register 5 -> BusyCnt=31 and unchanged; assert Rst_n=0 between clock edges -> BusyCnt=0 immediately.
REQ-041 With BYPASS=0, write Rw=4 with 0000BEEF while Ra=4 -> busA shows old value 00000000 that cycle, then 0000BEEF after the edge.
